bitstream_byte_feeder: RTL and testbench

Front-end feeder for the arithmetic decoder. It accepts 32-bit slice-data words from the bitstream memory interface and unpacks them MSB-byte-first into a small byte FIFO. It presents one byte at a time, show-ahead, to the decoder's byte-read stage, which pulls a byte whenever its value register needs refilling. Optionally it strips H.266 emulation-prevention bytes, so the decoder sees raw RBSP bytes.

---
 rtl/bitstream_pkg.sv | 11 +
 rtl/bitstream_byte_feeder_if.sv | 20 ++
 rtl/bitstream_byte_feeder_byte_fifo.sv | 37 +++
 rtl/bitstream_byte_feeder.sv | 91 +++++++++
 tb/tb_bitstream_byte_feeder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bitstream_pkg.sv
// bitstream_pkg: shared widths, EPB constant, unpacker states and FIFO entry type for the byte feeder
package bitstream_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam logic [BYTE_W-1:0] EPB_BYTE = 8'h03;
  typedef enum logic {IDLE, UNPACK} unpack_state_t;
  typedef struct packed {
    logic last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/bitstream_byte_feeder_if.sv
// bitstream_byte_feeder_if: word input and byte output handshakes of the byte feeder
interface bitstream_byte_feeder_if;
  import bitstream_pkg::*;
  logic [WORD_W-1:0] word_in;
  logic word_valid;
  logic word_last;
  logic word_ready;
  logic [BYTE_W-1:0] byte_out;
  logic byte_valid;
  logic byte_last;
  logic byte_req;
  modport master (
    output word_in, word_valid, word_last, byte_req,
    input word_ready, byte_out, byte_valid, byte_last
  );
  modport slave (
    input word_in, word_valid, word_last, byte_req,
    output word_ready, byte_out, byte_valid, byte_last
  );
endinterface

// File: rtl/bitstream_byte_feeder_byte_fifo.sv
// byte_fifo: show-ahead FIFO of {last, byte} entries with synchronous flush and occupancy count
module byte_fifo
  import bitstream_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  input logic push,
  input logic pop,
  input fifo_entry_t din,
  output fifo_entry_t head,
  output logic valid,
  output logic [AW:0] count
);
  fifo_entry_t mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  assign head = mem[rd];
  assign valid = count != '0;
  // storage needs no reset: the head is only observed when count is non-zero
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/bitstream_byte_feeder.sv
// bitstream_byte_feeder: unpacks 32-bit words MSB-first into a show-ahead byte FIFO; BYTE_FEEDER_EPB_EN strips emulation-prevention bytes
module bitstream_byte_feeder
  import bitstream_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  bitstream_byte_feeder_if.slave bus,
  output logic [CNT_W-1:0] bytes_consumed,
  output logic underflow
);
  localparam int AW = $clog2(DEPTH);
  unpack_state_t state;
  logic [WORD_W-1:0] hold;
  logic hold_last;
  logic [1:0] idx;
  logic [AW:0] count;
  fifo_entry_t head;
  fifo_entry_t din;
  logic valid;
  logic full;
  logic push;
  logic pop;
  logic drop;
  logic adv;
  logic [BYTE_W-1:0] cur;
  logic cur_last;
  assign cur = hold[{~idx, 3'b000} +: BYTE_W];
  assign cur_last = hold_last && idx == 2'd3;
  assign full = count == (AW+1)'(DEPTH);
`ifdef BYTE_FEEDER_EPB_EN
  logic [1:0] zrun;
  assign drop = state == UNPACK && cur == EPB_BYTE && zrun == 2'd2 && !cur_last;
  // zero run follows bytes leaving the unpacker, so a 00 00 03 split across words is still caught
  always_ff @(posedge clk)
    if (!rst_n || flush) zrun <= '0;
    else if (drop) zrun <= '0;
    else if (push) zrun <= cur != '0 ? 2'd0 : zrun == 2'd2 ? 2'd2 : zrun + 2'd1;
`else
  assign drop = 1'b0;
`endif
  assign push = state == UNPACK && !drop && !full;
  assign adv = push || drop;
  assign pop = bus.byte_req && valid;
  assign din = '{last: cur_last, data: cur};
  assign bus.word_ready = state == IDLE;
  assign bus.byte_valid = valid;
  assign bus.byte_out = valid ? head.data : '0;
  assign bus.byte_last = valid && head.last;
  // unpacker: load a word in IDLE, then walk bytes 0..3, holding the index while the FIFO is full
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      state <= IDLE;
      hold <= '0;
      hold_last <= 1'b0;
      idx <= '0;
    end else if (state == IDLE) begin
      if (bus.word_valid) begin
        state <= UNPACK;
        hold <= bus.word_in;
        hold_last <= bus.word_last;
        idx <= '0;
      end
    end else if (adv) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) state <= IDLE;
    end
  // consumed-byte counter wraps; underflow is sticky until reset or flush
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      bytes_consumed <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop) bytes_consumed <= bytes_consumed + CNT_W'(1);
      if (bus.byte_req && !valid) underflow <= 1'b1;
    end
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .valid(valid),
    .count(count)
  );
endmodule

// File: tb/tb_bitstream_byte_feeder.sv
// tb_bitstream_byte_feeder: directed timing/boundary checks plus randomized run against a stream-level model
module tb_bitstream_byte_feeder;
  localparam int DEPTH = 8;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [CW-1:0] bytes_consumed;
  logic underflow;
  int checks = 0;
  int errors = 0;
  logic [8:0] mq [$];
  int mz;
  logic [CW-1:0] mcnt;
  logic muf;
  bitstream_byte_feeder_if bus();
  bitstream_byte_feeder #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus.slave),
    .bytes_consumed(bytes_consumed),
    .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask
  task automatic send(input logic [31:0] w, input logic l);
    int n;
    n = 0;
    bus.word_in = w;
    bus.word_valid = 1'b1;
    bus.word_last = l;
    while (!bus.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.word_ready) chk("send_timeout", bus.word_ready, 1);
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.word_last = 1'b0;
  endtask
  task automatic pop_exp(input string tag, input logic [7:0] b, input logic l);
    int n;
    n = 0;
    while (!bus.byte_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_valid) chk({tag, "_timeout"}, bus.byte_valid, 1);
    chk({tag, "_data"}, bus.byte_out, b);
    chk({tag, "_last"}, bus.byte_last, l);
    bus.byte_req = 1'b1;
    @(negedge clk);
    bus.byte_req = 1'b0;
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      int r;
      r = $urandom_range(0, 3);
      w[8*i +: 8] = r == 0 ? 8'h00 : r == 1 ? 8'h03 : 8'($urandom);
    end
    return w;
  endfunction
  function automatic void model_word(input logic [31:0] w, input logic l);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      logic tag;
      b = w[31-8*i -: 8];
      tag = l && i == 3;
`ifdef BYTE_FEEDER_EPB_EN
      if (b == 8'h03 && mz == 2 && !tag) begin
        mz = 0;
        continue;
      end
      mz = b != 8'h00 ? 0 : (mz == 2 ? 2 : mz + 1);
`endif
      mq.push_back({tag, b});
    end
  endfunction
  initial begin
    logic [8:0] exp [$];
    bus.word_in = '0;
    bus.word_valid = 1'b0;
    bus.word_last = 1'b0;
    bus.byte_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", bus.word_ready, 1);
    chk("rst_valid", bus.byte_valid, 0);
    chk("rst_out", bus.byte_out, 0);
    chk("rst_last", bus.byte_last, 0);
    chk("rst_cnt", bytes_consumed, 0);
    chk("rst_uf", underflow, 0);
    bus.word_in = 32'h11223344;
    bus.word_valid = 1'b1;
    @(negedge clk);
    bus.word_valid = 1'b0;
    chk("t1_rdy_e0", bus.word_ready, 0);
    chk("t1_vld_e0", bus.byte_valid, 0);
    @(negedge clk);
    chk("t1_vld_e1", bus.byte_valid, 1);
    chk("t1_out_e1", bus.byte_out, 8'h11);
    chk("t1_rdy_e1", bus.word_ready, 0);
    @(negedge clk);
    chk("t1_rdy_e2", bus.word_ready, 0);
    @(negedge clk);
    chk("t1_rdy_e3", bus.word_ready, 0);
    @(negedge clk);
    chk("t1_rdy_e4", bus.word_ready, 1);
    pop_exp("t1_b0", 8'h11, 0);
    pop_exp("t1_b1", 8'h22, 0);
    pop_exp("t1_b2", 8'h33, 0);
    pop_exp("t1_b3", 8'h44, 0);
    chk("t1_cnt", bytes_consumed, 4);
    repeat (2) @(negedge clk);
    chk("t1_empty", bus.byte_valid, 0);
    do_flush();
    chk("t2_cnt0", bytes_consumed, 0);
    send(32'hA0A1A2A3, 0);
    send(32'hB0B1B2B3, 0);
    send(32'hC0C1C2C3, 0);
    repeat (10) @(negedge clk);
    chk("t2_stall", bus.word_ready, 0);
    chk("t2_vld", bus.byte_valid, 1);
    pop_exp("t2_p0", 8'hA0, 0);
    repeat (4) @(negedge clk);
    chk("t2_stall2", bus.word_ready, 0);
    for (int k = 1; k < 12; k++) pop_exp("t2_p", 8'((10 + k / 4) * 16 + k % 4), 0);
    repeat (3) @(negedge clk);
    chk("t2_rdy", bus.word_ready, 1);
    chk("t2_empty", bus.byte_valid, 0);
    for (int l = 0; l < 2; l++) begin
      do_flush();
      send(32'h00000311, 0);
      send(32'h22000003, 1'(l));
`ifdef BYTE_FEEDER_EPB_EN
      exp = '{9'h000, 9'h000, 9'h011, 9'h022, 9'h000, 9'h000};
      if (l == 1) exp.push_back(9'h103);
`else
      exp = '{9'h000, 9'h000, 9'h003, 9'h011, 9'h022, 9'h000, 9'h000};
      exp.push_back(l == 1 ? 9'h103 : 9'h003);
`endif
      foreach (exp[i]) pop_exp("t3_epb", exp[i][7:0], exp[i][8]);
      repeat (8) @(negedge clk);
      chk("t3_drained", bus.byte_valid, 0);
    end
    do_flush();
    bus.byte_req = 1'b1;
    @(negedge clk);
    bus.byte_req = 1'b0;
    chk("t4_uf", underflow, 1);
    chk("t4_cnt", bytes_consumed, 0);
    send(32'h55667788, 0);
    repeat (2) @(negedge clk);
    chk("t4_uf_sticky", underflow, 1);
    chk("t4_vld", bus.byte_valid, 1);
    do_flush();
    chk("t4_uf_clr", underflow, 0);
    chk("t4_vld_clr", bus.byte_valid, 0);
    chk("t4_rdy_clr", bus.word_ready, 1);
    do_flush();
    for (int k = 0; k < 64; k++) begin
      send(32'hAABBCC44, 1'(k == 63));
      pop_exp("t5_aa", 8'hAA, 0);
      pop_exp("t5_bb", 8'hBB, 0);
      pop_exp("t5_cc", 8'hCC, 0);
      if (k == 63) chk("t5_cnt255", bytes_consumed, 255);
      pop_exp("t5_44", 8'h44, 1'(k == 63));
    end
    chk("t5_wrap", bytes_consumed, 0);
    do_flush();
    mq.delete();
    mz = 0;
    mcnt = '0;
    muf = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      chk("r_cnt", bytes_consumed, mcnt);
      chk("r_uf", underflow, muf);
      if (mq.size() == 0) chk("r_vld_empty", bus.byte_valid, 0);
      flush = $urandom_range(0, 99) == 0;
      bus.word_valid = 1'($urandom_range(0, 1));
      bus.word_last = $urandom_range(0, 7) == 0;
      bus.word_in = rand_word();
      bus.byte_req = ((c / 500) % 2 == 1) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      if (flush) begin
        mq.delete();
        mz = 0;
        mcnt = '0;
        muf = 1'b0;
      end else begin
        if (bus.byte_req && bus.byte_valid && mq.size() != 0) begin
          chk("r_data", {bus.byte_last, bus.byte_out}, mq[0]);
          void'(mq.pop_front());
          mcnt = mcnt + 1'b1;
        end
        if (bus.byte_req && !bus.byte_valid) muf = 1'b1;
        if (bus.word_valid && bus.word_ready) model_word(bus.word_in, bus.word_last);
      end
      @(negedge clk);
    end
    flush = 1'b0;
    bus.word_valid = 1'b0;
    bus.byte_req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
